// File: rtl/mips_pipeline_core_pkg.sv
// Shared opcode/funct/ALU encodings, pipeline register layouts and the main decoder.
// Latency: n/a (package); backpressure: n/a.
package mips_pipeline_core_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic       jump;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic [2:0]  alu_ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } de_reg_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic [31:0] alu_out;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
    } em_reg_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] alu_out;
        logic [31:0] read_data;
        logic [4:0]  write_reg;
    } mw_reg_t;

    // Anything not recognised decodes to all-zero controls, i.e. a NOP.
    function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                case (funct)
                    FN_ADD:  c.alu_ctrl = ALU_ADD;
                    FN_SUB:  c.alu_ctrl = ALU_SUB;
                    FN_AND:  c.alu_ctrl = ALU_AND;
                    FN_OR:   c.alu_ctrl = ALU_OR;
                    FN_SLT:  c.alu_ctrl = ALU_SLT;
                    default: c = '0;
                endcase
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = ALU_ADD;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = ALU_ADD;
            end
            OP_BEQ:  c.branch = 1'b1;
            OP_J:    c.jump   = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] ctrl);
        case (ctrl)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/mips_pipeline_core_hazard.sv
// Forwarding selects plus load-use / branch-operand stall detection.
// Latency: purely combinational; backpressure: stall_f/stall_d freeze front end, flush_e injects a bubble.
module mips_hazard_unit
    import mips_pipeline_core_pkg::*;
(
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] write_reg_e,
    input  logic [4:0] write_reg_m,
    input  logic [4:0] write_reg_w,
    input  logic       branch_d,
    input  logic       reg_write_e,
    input  logic       mem_to_reg_e,
    input  logic       reg_write_m,
    input  logic       mem_to_reg_m,
    input  logic       reg_write_w,
    output logic       fwd_a_d,
    output logic       fwd_b_d,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_e
);

    function automatic fwd_t pick(input logic [4:0] src, input logic wr_m, input logic [4:0] dst_m,
                                  input logic wr_w, input logic [4:0] dst_w);
        if (src != 5'd0 && wr_m && dst_m == src) return FWD_M;
        if (src != 5'd0 && wr_w && dst_w == src) return FWD_W;
        return FWD_RF;
    endfunction

    logic load_use;
    logic branch_stall;

    assign fwd_a_e = pick(rs_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    assign fwd_b_e = pick(rt_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);

    assign fwd_a_d = (rs_d != 5'd0) && reg_write_m && (write_reg_m == rs_d);
    assign fwd_b_d = (rt_d != 5'd0) && reg_write_m && (write_reg_m == rt_d);

    assign load_use     = mem_to_reg_e && ((rt_e == rs_d) || (rt_e == rt_d));
    // beq compares in Decode, so a producer still in E (or a load in M) is not yet usable.
    assign branch_stall = branch_d &&
                          ((reg_write_e  && ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
                           (mem_to_reg_m && ((write_reg_m == rs_d) || (write_reg_m == rt_d))));

    assign stall_f = load_use | branch_stall;
    assign stall_d = load_use | branch_stall;
    assign flush_e = load_use | branch_stall;

endmodule

// File: rtl/mips_pipeline_core.sv
// Five-stage MIPS32 integer pipeline (F/D/E/M/W) with full forwarding and Decode-resolved branches.
// Latency: 5 cycles issue-to-writeback; backpressure: none external, internal hazards stall F/D.
module mips_pipeline_core
    import mips_pipeline_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        memwrite,
    output logic [31:0] dataadr,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    logic [31:0] pc_plus4_f;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic [31:0] rf [32];
    de_reg_t     de;
    de_reg_t     de_next;
    em_reg_t     em;
    mw_reg_t     mw;

    logic        stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d;
    logic [1:0]  fwd_a_e, fwd_b_e;

    ctrl_t       ctrl_d;
    logic [4:0]  rs_d, rt_d, rd_d;
    logic [31:0] imm_d, rd1_d, rd2_d, cmp_a_d, cmp_b_d, target_d;
    logic        redirect_d;

    logic [31:0] src_a_e, write_data_e, src_b_e, alu_out_e;
    logic [4:0]  write_reg_e;
    logic [31:0] result_w;

    assign pc_plus4_f = pc + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (!stall_f) begin
            pc <= redirect_d ? target_d : pc_plus4_f;
        end
    end

    // An all-zero word decodes as a NOP, so clearing instr_d is the F/D flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_d    <= '0;
            pc_plus4_d <= '0;
        end else if (!stall_d) begin
            instr_d    <= redirect_d ? 32'd0 : instr;
            pc_plus4_d <= pc_plus4_f;
        end
    end

    assign ctrl_d = decode_ctrl(instr_d[31:26], instr_d[5:0]);
    assign rs_d   = instr_d[25:21];
    assign rt_d   = instr_d[20:16];
    assign rd_d   = instr_d[15:11];
    assign imm_d  = {{16{instr_d[15]}}, instr_d[15:0]};

    // Register file reads see the same-cycle Writeback value.
    assign rd1_d = (rs_d == 5'd0) ? 32'd0 :
                   (mw.reg_write && mw.write_reg == rs_d) ? result_w : rf[rs_d];
    assign rd2_d = (rt_d == 5'd0) ? 32'd0 :
                   (mw.reg_write && mw.write_reg == rt_d) ? result_w : rf[rt_d];

    assign cmp_a_d    = fwd_a_d ? em.alu_out : rd1_d;
    assign cmp_b_d    = fwd_b_d ? em.alu_out : rd2_d;
    assign redirect_d = !stall_d && (ctrl_d.jump || (ctrl_d.branch && (cmp_a_d == cmp_b_d)));
    assign target_d   = ctrl_d.jump ? {pc_plus4_d[31:28], instr_d[25:0], 2'b00}
                                    : pc_plus4_d + {imm_d[29:0], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (mw.reg_write && mw.write_reg != 5'd0) begin
            rf[mw.write_reg] <= result_w;
        end
    end

    always_comb begin
        de_next            = '0;
        de_next.reg_write  = ctrl_d.reg_write;
        de_next.mem_to_reg = ctrl_d.mem_to_reg;
        de_next.mem_write  = ctrl_d.mem_write;
        de_next.alu_src    = ctrl_d.alu_src;
        de_next.reg_dst    = ctrl_d.reg_dst;
        de_next.alu_ctrl   = ctrl_d.alu_ctrl;
        de_next.rd1        = rd1_d;
        de_next.rd2        = rd2_d;
        de_next.imm        = imm_d;
        de_next.rs         = rs_d;
        de_next.rt         = rt_d;
        de_next.rd         = rd_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de <= '0;
        end else if (flush_e) begin
            de <= '0;
        end else begin
            de <= de_next;
        end
    end

    always_comb begin
        case (fwd_a_e)
            FWD_M:   src_a_e = em.alu_out;
            FWD_W:   src_a_e = result_w;
            default: src_a_e = de.rd1;
        endcase
        case (fwd_b_e)
            FWD_M:   write_data_e = em.alu_out;
            FWD_W:   write_data_e = result_w;
            default: write_data_e = de.rd2;
        endcase
    end

    assign src_b_e     = de.alu_src ? de.imm : write_data_e;
    assign alu_out_e   = alu(src_a_e, src_b_e, de.alu_ctrl);
    assign write_reg_e = de.reg_dst ? de.rd : de.rt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            em <= '0;
        end else begin
            em.reg_write  <= de.reg_write;
            em.mem_to_reg <= de.mem_to_reg;
            em.mem_write  <= de.mem_write;
            em.alu_out    <= alu_out_e;
            em.write_data <= write_data_e;
            em.write_reg  <= write_reg_e;
        end
    end

    assign memwrite  = em.mem_write;
    assign dataadr   = em.alu_out;
    assign writedata = em.write_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mw <= '0;
        end else begin
            mw.reg_write  <= em.reg_write;
            mw.mem_to_reg <= em.mem_to_reg;
            mw.alu_out    <= em.alu_out;
            mw.read_data  <= readdata;
            mw.write_reg  <= em.write_reg;
        end
    end

    assign result_w = mw.mem_to_reg ? mw.read_data : mw.alu_out;

    mips_hazard_unit u_hazard (
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .rs_e         (de.rs),
        .rt_e         (de.rt),
        .write_reg_e  (write_reg_e),
        .write_reg_m  (em.write_reg),
        .write_reg_w  (mw.write_reg),
        .branch_d     (ctrl_d.branch),
        .reg_write_e  (de.reg_write),
        .mem_to_reg_e (de.mem_to_reg),
        .reg_write_m  (em.reg_write),
        .mem_to_reg_m (em.mem_to_reg),
        .reg_write_w  (mw.reg_write),
        .fwd_a_d      (fwd_a_d),
        .fwd_b_d      (fwd_b_d),
        .fwd_a_e      (fwd_a_e),
        .fwd_b_e      (fwd_b_e),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_e      (flush_e)
    );

endmodule

// File: tb/tb_mips_pipeline_core.sv
// Directed bench for mips_pipeline_core: small programs in a 64-word ROM, stores logged at negedge.
// Latency: n/a; backpressure: n/a.
module tb_mips_pipeline_core;
    import mips_pipeline_core_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, instr, dataadr, writedata, readdata;
    logic        memwrite;

    logic [31:0] rom [64];
    logic [31:0] ram [64];
    logic [31:0] pc_trace [$];
    logic [31:0] st_adr [$];
    logic [31:0] st_dat [$];
    int          passed = 0;
    int          total  = 0;

    mips_pipeline_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .instr     (instr),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata)
    );

    always #5 clk = ~clk;

    assign instr    = rom[pc[7:2]];
    assign readdata = ram[dataadr[7:2]];

    always @(posedge clk) if (memwrite) ram[dataadr[7:2]] <= writedata;

    always @(negedge clk) begin
        if (!reset) begin
            pc_trace.push_back(pc);
            if (memwrite) begin
                st_adr.push_back(dataadr);
                st_dat.push_back(writedata);
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt, input int rd);
        return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        return {OP_J, 26'(target)};
    endfunction

    task automatic begin_test();
        @(negedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 64; i++) rom[i] = 32'd0;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        total++; if (pc !== 32'd0) $display("FAIL reset_pc_a: got %h want 0", pc); else passed++;
        total++; if (memwrite !== 1'b0) $display("FAIL reset_memwrite: got %b want 0", memwrite); else passed++;
        @(posedge clk); #1;
        total++; if (pc !== 32'd0) $display("FAIL reset_pc_b: got %h want 0", pc); else passed++;
        @(negedge clk);
        #2 reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            total++;
            if (pc !== 32'(4 * k)) $display("FAIL seq_pc_%0d: got %h want %h", k, pc, 32'(4 * k));
            else passed++;
            total++;
            if (memwrite !== 1'b0) $display("FAIL seq_memwrite_%0d: got %b want 0", k, memwrite);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int ts, ss, holds;
        begin_test();
        rom[0] = enc_i(OP_ADDI, 0, 2, 5);
        rom[1] = enc_i(OP_ADDI, 2, 3, 7);
        rom[2] = enc_i(OP_SW, 0, 3, 84);
        release_reset();
        ts = pc_trace.size(); ss = st_adr.size();
        repeat (10) @(negedge clk);
        holds = 0;
        for (int i = ts + 1; i < pc_trace.size(); i++) if (pc_trace[i] == pc_trace[i-1]) holds++;
        total++; if (st_adr.size() - ss != 1) $display("FAIL b2b_store_count: got %0d want 1", st_adr.size() - ss); else passed++;
        total++; if (st_adr[ss] !== 32'd84) $display("FAIL b2b_adr: got %0d want 84", st_adr[ss]); else passed++;
        total++; if (st_dat[ss] !== 32'd12) $display("FAIL b2b_data: got %0d want 12", st_dat[ss]); else passed++;
        total++; if (holds != 0) $display("FAIL b2b_stalls: got %0d want 0", holds); else passed++;
    endtask

    task automatic test_rf_reset();
        int ss;
        begin_test();
        rom[0] = enc_i(OP_SW, 0, 3, 0);
        rom[1] = enc_i(OP_SW, 0, 2, 4);
        release_reset();
        ss = st_adr.size();
        repeat (8) @(negedge clk);
        total++; if (st_adr.size() - ss != 2) $display("FAIL rfrst_store_count: got %0d want 2", st_adr.size() - ss); else passed++;
        total++; if (st_dat[ss] !== 32'd0) $display("FAIL rfrst_r3: got %h want 0", st_dat[ss]); else passed++;
        total++; if (st_dat[ss+1] !== 32'd0) $display("FAIL rfrst_r2: got %h want 0", st_dat[ss+1]); else passed++;
    endtask

    task automatic test_zero_and_nop();
        int ss;
        begin_test();
        rom[0] = enc_i(OP_ADDI, 0, 0, 5);
        rom[1] = enc_i(OP_SW, 0, 0, 0);
        rom[2] = enc_i(6'h0D, 0, 7, 5);
        rom[3] = enc_r(6'h27, 0, 0, 8);
        rom[5] = enc_i(OP_SW, 0, 7, 4);
        rom[6] = enc_i(OP_SW, 0, 8, 8);
        release_reset();
        ss = st_adr.size();
        repeat (12) @(negedge clk);
        total++; if (st_adr.size() - ss != 3) $display("FAIL zero_store_count: got %0d want 3", st_adr.size() - ss); else passed++;
        total++; if (st_dat[ss] !== 32'd0) $display("FAIL zero_r0: got %h want 0", st_dat[ss]); else passed++;
        total++; if (st_dat[ss+1] !== 32'd0) $display("FAIL nop_ori: got %h want 0", st_dat[ss+1]); else passed++;
        total++; if (st_dat[ss+2] !== 32'd0) $display("FAIL nop_nor: got %h want 0", st_dat[ss+2]); else passed++;
    endtask

    task automatic test_alu();
        int ss;
        logic [31:0] exp_d [6];
        begin_test();
        rom[0]  = enc_i(OP_ADDI, 0, 1, -1);
        rom[1]  = enc_i(OP_ADDI, 0, 2, 1);
        rom[2]  = enc_r(FN_SLT, 1, 2, 3);
        rom[3]  = enc_r(FN_SLT, 2, 1, 4);
        rom[4]  = enc_r(FN_SUB, 2, 1, 5);
        rom[5]  = enc_r(FN_AND, 1, 2, 6);
        rom[6]  = enc_r(FN_OR,  1, 2, 7);
        rom[7]  = enc_r(FN_ADD, 1, 1, 8);
        for (int i = 0; i < 6; i++) rom[8+i] = enc_i(OP_SW, 0, 3 + i, 4 * i);
        exp_d[0] = 32'd1; exp_d[1] = 32'd0; exp_d[2] = 32'd2;
        exp_d[3] = 32'd1; exp_d[4] = 32'hFFFF_FFFF; exp_d[5] = 32'hFFFF_FFFE;
        release_reset();
        ss = st_adr.size();
        repeat (20) @(negedge clk);
        total++; if (st_adr.size() - ss != 6) $display("FAIL alu_store_count: got %0d want 6", st_adr.size() - ss); else passed++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (st_dat[ss+i] !== exp_d[i]) $display("FAIL alu_result_%0d: got %h want %h", i, st_dat[ss+i], exp_d[i]);
            else passed++;
        end
    endtask

    task automatic test_load_use();
        int ts, ss, holds;
        begin_test();
        rom[0] = enc_i(OP_ADDI, 0, 1, 9);
        rom[1] = enc_i(OP_SW, 0, 1, 0);
        rom[2] = enc_i(OP_LW, 0, 4, 0);
        rom[3] = enc_r(FN_ADD, 4, 4, 5);
        rom[4] = enc_i(OP_SW, 0, 5, 4);
        release_reset();
        ts = pc_trace.size(); ss = st_adr.size();
        repeat (12) @(negedge clk);
        holds = 0;
        for (int i = ts + 1; i < pc_trace.size(); i++) if (pc_trace[i] == pc_trace[i-1]) holds++;
        total++; if (holds != 1) $display("FAIL lu_stalls: got %0d want 1", holds); else passed++;
        total++; if (st_adr.size() - ss != 2) $display("FAIL lu_store_count: got %0d want 2", st_adr.size() - ss); else passed++;
        total++; if (st_adr[ss+1] !== 32'd4) $display("FAIL lu_adr: got %0d want 4", st_adr[ss+1]); else passed++;
        total++; if (st_dat[ss+1] !== 32'd18) $display("FAIL lu_data: got %0d want 18", st_dat[ss+1]); else passed++;
    endtask

    task automatic test_branch_taken();
        int ts, ss;
        logic [31:0] exp_pc [4];
        begin_test();
        rom[0] = enc_i(OP_ADDI, 0, 1, 3);
        rom[1] = enc_i(OP_BEQ, 1, 1, 2);
        rom[2] = enc_i(OP_ADDI, 0, 6, 1);
        rom[3] = enc_i(OP_ADDI, 0, 6, 2);
        rom[4] = enc_i(OP_SW, 0, 6, 8);
        rom[5] = enc_i(OP_SW, 0, 1, 12);
        exp_pc[0] = 32'd4; exp_pc[1] = 32'd8; exp_pc[2] = 32'd8; exp_pc[3] = 32'd16;
        release_reset();
        ts = pc_trace.size(); ss = st_adr.size();
        repeat (12) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pc_trace[ts+i] !== exp_pc[i]) $display("FAIL beq_pc_%0d: got %h want %h", i, pc_trace[ts+i], exp_pc[i]);
            else passed++;
        end
        total++; if (st_adr.size() - ss != 2) $display("FAIL beq_store_count: got %0d want 2", st_adr.size() - ss); else passed++;
        total++; if (st_dat[ss] !== 32'd0) $display("FAIL beq_squash: got %h want 0", st_dat[ss]); else passed++;
        total++; if (st_dat[ss+1] !== 32'd3) $display("FAIL beq_r1: got %h want 3", st_dat[ss+1]); else passed++;
    endtask

    task automatic test_branch_not_taken();
        int ts, ss;
        begin_test();
        rom[0] = enc_i(OP_ADDI, 0, 1, 3);
        rom[1] = enc_i(OP_ADDI, 0, 2, 4);
        rom[4] = enc_i(OP_BEQ, 1, 2, 2);
        rom[5] = enc_i(OP_ADDI, 0, 6, 7);
        rom[6] = enc_i(OP_SW, 0, 6, 8);
        release_reset();
        ts = pc_trace.size(); ss = st_adr.size();
        repeat (12) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (pc_trace[ts+k] !== 32'(4 * (k + 1))) $display("FAIL bnt_pc_%0d: got %h want %h", k, pc_trace[ts+k], 32'(4 * (k + 1)));
            else passed++;
        end
        total++; if (st_adr.size() - ss != 1) $display("FAIL bnt_store_count: got %0d want 1", st_adr.size() - ss); else passed++;
        total++; if (st_dat[ss] !== 32'd7) $display("FAIL bnt_data: got %h want 7", st_dat[ss]); else passed++;
    endtask

    task automatic test_jump();
        int ts, ss;
        logic [31:0] exp_pc [5];
        begin_test();
        rom[2]  = enc_j(32'h10);
        rom[3]  = enc_i(OP_ADDI, 0, 6, 1);
        rom[16] = enc_i(OP_SW, 0, 6, 8);
        exp_pc[0] = 32'd4; exp_pc[1] = 32'd8; exp_pc[2] = 32'd12; exp_pc[3] = 32'h40; exp_pc[4] = 32'h44;
        release_reset();
        ts = pc_trace.size(); ss = st_adr.size();
        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (pc_trace[ts+i] !== exp_pc[i]) $display("FAIL j_pc_%0d: got %h want %h", i, pc_trace[ts+i], exp_pc[i]);
            else passed++;
        end
        total++; if (st_adr.size() - ss != 1) $display("FAIL j_store_count: got %0d want 1", st_adr.size() - ss); else passed++;
        total++; if (st_dat[ss] !== 32'd0) $display("FAIL j_squash: got %h want 0", st_dat[ss]); else passed++;
    endtask

    task automatic test_regression();
        int ss, n, bad84;
        begin_test();
        rom[0]  = enc_i(OP_ADDI, 0, 2, 5);
        rom[1]  = enc_i(OP_ADDI, 0, 3, 12);
        rom[2]  = enc_i(OP_ADDI, 3, 7, -9);
        rom[3]  = enc_r(FN_OR,  7, 2, 4);
        rom[4]  = enc_r(FN_AND, 3, 4, 5);
        rom[5]  = enc_r(FN_ADD, 5, 4, 5);
        rom[6]  = enc_i(OP_BEQ, 5, 7, 10);
        rom[7]  = enc_r(FN_SLT, 3, 4, 4);
        rom[8]  = enc_i(OP_BEQ, 4, 0, 1);
        rom[9]  = enc_i(OP_ADDI, 0, 5, 0);
        rom[10] = enc_r(FN_SLT, 7, 2, 4);
        rom[11] = enc_r(FN_ADD, 4, 5, 7);
        rom[12] = enc_r(FN_SUB, 7, 2, 7);
        rom[13] = enc_i(OP_SW, 3, 7, 68);
        rom[14] = enc_i(OP_LW, 0, 2, 80);
        rom[15] = enc_j(32'h11);
        rom[16] = enc_i(OP_ADDI, 0, 2, 1);
        rom[17] = enc_i(OP_SW, 0, 2, 84);
        release_reset();
        ss = st_adr.size();
        repeat (40) @(negedge clk);
        n = st_adr.size() - ss;
        bad84 = 0;
        for (int i = ss; i < st_adr.size(); i++) if (st_adr[i] == 32'd84 && st_dat[i] != 32'd7) bad84++;
        total++; if (n != 2) $display("FAIL reg_store_count: got %0d want 2", n); else passed++;
        total++; if (st_adr[ss+1] !== 32'd84) $display("FAIL reg_final_adr: got %0d want 84", st_adr[ss+1]); else passed++;
        total++; if (st_dat[ss+1] !== 32'd7) $display("FAIL reg_final_data: got %0d want 7", st_dat[ss+1]); else passed++;
        total++; if (bad84 != 0) $display("FAIL reg_bad_84: got %0d want 0", bad84); else passed++;
        total++; if (st_adr[ss] !== 32'd80 || st_dat[ss] !== 32'd7) $display("FAIL reg_first_store: got %0d/%0d want 80/7", st_adr[ss], st_dat[ss]); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'd0;
        reset = 1'b0;
        #1 reset = 1'b1;
        test_reset();
        test_back_to_back();
        test_rf_reset();
        test_zero_and_nop();
        test_alu();
        test_load_use();
        test_branch_taken();
        test_branch_not_taken();
        test_jump();
        test_regression();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mips_pipeline_core.md
Name: mips_pipeline_core

Overview:
- Five-stage pipelined MIPS32 integer core: Fetch, Decode, Execute, Memory, Writeback.
- Full forwarding and hazard handling.
- Connects to an external combinational instruction memory and to a data memory with combinational read and synchronous write.
- Sits under the system top level, between the instruction ROM (indexed by pc[7:2]) and the data RAM.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc  output  32  Fetch-stage program counter (instruction address).
- instr  input  32  instruction at pc; combinational, returned in the same cycle.
- memwrite  output  1  Memory-stage store enable.
- dataadr  output  32  Memory-stage ALU result (load/store byte address).
- writedata  output  32  Memory-stage store data.
- readdata  input  32  load data for dataadr; combinational, same cycle.

Behaviour:
- Reset:
  - Asserted asynchronously: pc=RESET_PC.
  - All pipeline registers cleared, so every stage holds a bubble with all control bits 0; memwrite=0.
  - All 32 register-file entries are cleared to 0.
- Supported ISA (any other opcode/funct executes as a NOP, with no register or memory write):
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- Arithmetic and widths:
  - 32-bit wrap-around arithmetic; no overflow traps.
  - slt is a signed compare producing 1 or 0.
  - The immediate is sign-extended for all I-type instructions.
- Register file:
  - 32x32, two read ports and one write port; $0 always reads 0 and ignores writes.
  - A Writeback write is visible to a Decode read in the same cycle (internal write-before-read bypass).
- Fetch: pc advances by 4 each cycle unless stalled or redirected.
- Branch and jump resolution:
  - beq is resolved in Decode: equality compare on the Decode operands, target = PCPlus4D + (signimm<<2).
  - j is resolved in Decode: target = {PCPlus4D[31:28], instr[25:0], 2'b00}.
  - Taken beq or j: redirect pc and flush the F/D register, costing 1 bubble. There is no delay slot.
- Forwarding into Execute ALU sources, for each source rs/rt:
  - Use the M-stage result if RegWriteM and WriteRegM == src and src != 0.
  - Else use the W-stage result under the same condition.
  - Else use the register-file value. M has priority over W.
- Forwarding into the Decode branch compare: from ALUOutM when RegWriteM, WriteRegM == rsD/rtD, and that register is nonzero.
- Stalls (freeze pc and F/D, flush D/E):
  - Load-use: lw in Execute whose rt matches rsD or rtD.
  - Branch hazard: beq in Decode whose source is written by the E-stage instruction, or by an lw in Memory.
- Simultaneous events: a stall has priority over a redirect. A beq evaluated while stalled does not redirect until its operands are valid.
- Memory stage: memwrite, dataadr, writedata come directly from the E/M register. Store data uses the forwarded rt value.
- Writeback: result = readdata (registered at M/W) for lw, else the ALU result. The write occurs on the rising edge at the end of W.

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct constants;
  - the 3-bit ALU control encoding: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- One natural sub-module: mips_hazard_unit, which computes the forwarding selects, stallF/stallD, and flushE.
- Controller, datapath and register file are internal blocks of the core.
- Instruction memory is external: 64x32 ROM read combinationally at pc[7:2].

Test Plan:
- Reset and sequential fetch: reset high for 2 cycles, then release with a NOP program → pc=0 during reset, then 4, 8, 12 on successive edges; memwrite stays 0.
- Back-to-back dependency: addi $2,$0,5; addi $3,$2,7; sw $3,84($0) → forwarding gives one cycle with memwrite=1, dataadr=84, writedata=12, and no stall cycles.
- Load-use: memory word 0 = 9; lw $4,0($0); add $5,$4,$4; sw $5,4($0) → pc holds for exactly 1 cycle; store shows dataadr=4, writedata=18.
- Branch taken and not taken:
  - beq $1,$1,+2 → the next sequential instruction is flushed; there is no write from it or the skipped instruction.
  - beq with unequal operands falls through with no bubble.
- Jump: j 0x10 at address 8 → pc sequence 8, 12, then 0x40; the instruction at 12 is squashed.
- Full regression: standard 18-instruction test program (add/sub/and/or/slt/addi/beq/j/lw/sw) → the final store is memwrite=1, dataadr=84, writedata=7, and no store ever writes address 84 with any other value.
